// File: rtl/axi_seq_pkg.sv
// Shared types for the AXI4-Lite write/readback sequencer.
// Holds the FSM state enum, response codes, pattern tag and helpers.
package axi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } seq_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] PATTERN_TAG = 8'hA5;

    // Word i carries {tag, i, low 16 bits of ~i}.
    function automatic logic [31:0] pattern_word(input logic [7:0] idx);
        logic [15:0] wide;
        wide = {8'h00, idx};
        return {PATTERN_TAG, idx, ~wide};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
// Ports: ACLK, ARESETn; signals mirror the five AXI4-Lite channels.
interface axi4_lite_if #(
    parameter int ADDR_SIZE = 24
) (
    input logic ACLK,
    input logic ARESETn
);
    logic [ADDR_SIZE-1:0] awaddr;
    logic                 awvalid;
    logic                 awready;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [ADDR_SIZE-1:0] araddr;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport master (
        input  ACLK, ARESETn,
        output awaddr, awvalid, wdata, wstrb, wvalid,
        output bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  ACLK, ARESETn,
        input  awaddr, awvalid, wdata, wstrb, wvalid,
        input  bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_write_readback_seq.sv
// AXI4-Lite master: writes a pattern to NUM_WORDS words, reading each back.
// Ports: ACLK/ARESETn, start, AXI4-Lite master channels, busy/done/err_count/last_rdata/word_idx.
module axi_write_readback_seq
    import axi_seq_pkg::*;
#(
    parameter int                   ADDR_SIZE = 24,
    parameter int                   DATA_SIZE = 32,
    parameter int                   NUM_WORDS = 16,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 start,
    output logic [ADDR_SIZE-1:0] awaddr,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [DATA_SIZE-1:0] wdata,
    output logic [3:0]           wstrb,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready,
    output logic [ADDR_SIZE-1:0] araddr,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [DATA_SIZE-1:0] rdata,
    input  logic [1:0]           rresp,
    input  logic                 rvalid,
    output logic                 rready,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           err_count,
    output logic [DATA_SIZE-1:0] last_rdata,
    output logic [7:0]           word_idx
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    seq_state_e state, state_nxt;

    logic                 aw_done, w_done;
    logic                 aw_hs, w_hs;
    logic                 run_go;
    logic                 b_err, r_err;
    logic [ADDR_SIZE-1:0] cur_addr;
    logic [DATA_SIZE-1:0] cur_data;

    assign cur_addr = BASE_ADDR + ADDR_SIZE'({word_idx, 2'b00});
    assign cur_data = DATA_SIZE'(pattern_word(word_idx));

    // Each write channel retires on its own; the flags remember it.
    assign aw_hs  = (state == WR_REQ) && !aw_done && awready;
    assign w_hs   = (state == WR_REQ) && !w_done && wready;
    assign run_go = ((state == IDLE) || (state == DONE)) && start;
    assign b_err  = (state == WR_RESP) && bvalid && (bresp != RESP_OKAY);
    assign r_err  = (state == RD_RESP) && rvalid &&
                    ((rdata != cur_data) || (rresp != RESP_OKAY));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = WR_REQ;
            end
            WR_REQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_nxt = RD_REQ;
            end
            RD_REQ: begin
                arvalid = 1'b1;
                if (arready) state_nxt = RD_RESP;
            end
            RD_RESP: begin
                rready = 1'b1;
                if (rvalid)
                    state_nxt = (word_idx == LAST_IDX) ? DONE : WR_REQ;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_nxt = WR_REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payloads read as zero whenever their valid is low.
    assign awaddr = awvalid ? cur_addr : '0;
    assign araddr = arvalid ? cur_addr : '0;
    assign wdata  = wvalid ? cur_data : '0;
    assign wstrb  = wvalid ? 4'hF : 4'h0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            word_idx   <= '0;
            err_count  <= '0;
            last_rdata <= '0;
        end else begin
            if (state == WR_REQ) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end

            if (run_go)              err_count <= '0;
            else if (b_err || r_err) err_count <= sat_inc8(err_count);

            if (run_go) begin
                word_idx <= '0;
            end else if ((state == RD_RESP) && rvalid) begin
                word_idx   <= word_idx + 8'd1;
                last_rdata <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_axi_write_readback_seq.sv
// Randomized scoreboard bench for axi_write_readback_seq.
// A slave model answers the DUT; expectations come from a reference model.
module tb_axi_write_readback_seq;

    localparam int          NW   = 4;
    localparam logic [23:0] BASE = 24'hFFFFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [31:0] wdata, rdata = 0, last_rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = 0, rresp = 0;
    logic        busy, done;
    logic [7:0]  err_count, word_idx;

    always #5 clk = ~clk;

    axi_write_readback_seq #(
        .ADDR_SIZE(24), .DATA_SIZE(32), .NUM_WORDS(NW), .BASE_ADDR(BASE)
    ) dut (
        .ACLK(clk), .ARESETn(rst_n), .start(start),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .busy(busy), .done(done), .err_count(err_count),
        .last_rdata(last_rdata), .word_idx(word_idx)
    );

    int checks = 0;
    int errors = 0;
    int mode = 1;   // 0 random, 1 zero-wait, 2 slow awready, 3 injected faults

    logic [23:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [23:0] exp_ar[$];
    logic [31:0] mem[logic [23:0]];
    int          exp_err;
    logic [31:0] last_exp;

    int          n_aw, n_w, n_b, n_ar;
    int          aw_hi, w_hi, aw_wait, w_wait, ar_wait, aw_dly, w_dly, ar_dly;
    bit          got_aw, got_w, b_pend, r_pend;
    int          b_cnt, r_cnt;
    logic [1:0]  b_code, r_code;
    logic [31:0] r_data, wr_data, w_prev;
    logic [23:0] wr_addr, aw_prev, ar_prev;
    bit          aw_stall, w_stall, ar_stall;

    function automatic logic [31:0] ref_pat(int i);
        int ni;
        ni = ~i;
        return {8'hA5, i[7:0], ni[15:0]};
    endfunction

    function automatic logic [23:0] ref_addr(int i);
        logic [23:0] a;
        a = BASE + 24'(4 * i);
        return a;
    endfunction

    function automatic int pick(int ch);
        case (mode)
            0:       return int'($urandom_range(0, 3));
            2:       return (ch == 0) ? 3 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=missing required=event", nm);
    endtask

    // Slave model and monitor. Values driven at a negedge are what the
    // DUT samples at the next posedge, so handshakes are resolved here.
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 0; rresp = 0; rdata = 0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; aw_hi = 0; w_hi = 0;
            aw_stall = 0; w_stall = 0; ar_stall = 0;
        end else begin
            if (aw_stall) chk("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
            if (w_stall)  chk("w_stable", {wvalid, wdata}, {1'b1, w_prev});
            if (ar_stall) chk("ar_stable", {arvalid, araddr}, {1'b1, ar_prev});
            chk("one_channel",
                ($countones({awvalid | wvalid, bready, arvalid, rready}) <= 1), 1);

            awready = awvalid && (aw_wait >= aw_dly);
            wready  = wvalid && (w_wait >= w_dly);
            arready = arvalid && (ar_wait >= ar_dly);
            bvalid  = 0;
            rvalid  = 0;
            if (b_pend) begin
                if (b_cnt == 0) begin bvalid = 1; bresp = b_code; end
                else b_cnt--;
            end
            if (r_pend) begin
                if (r_cnt == 0) begin rvalid = 1; rdata = r_data; rresp = r_code; end
                else r_cnt--;
            end

            if (awvalid) aw_hi++;
            if (wvalid)  w_hi++;

            if (awvalid && awready) begin
                if (exp_aw.size() == 0) fail("aw_extra");
                else chk("awaddr", awaddr, exp_aw.pop_front());
                if (mode == 2) begin
                    chk("aw_valid_cycles", aw_hi, 4);
                    chk("w_dropped", w_hi, 0);
                end
                aw_hi = 0; aw_wait = 0; aw_dly = pick(0);
                got_aw = 1; wr_addr = awaddr; n_aw++;
            end else if (awvalid) aw_wait++;

            if (wvalid && wready) begin
                if (exp_w.size() == 0) fail("w_extra");
                else chk("wdata", wdata, exp_w.pop_front());
                chk("wstrb", wstrb, 4'hF);
                if (mode == 2) chk("w_valid_cycles", w_hi, 1);
                w_hi = 0; w_wait = 0; w_dly = pick(1);
                got_w = 1; wr_data = wdata; n_w++;
            end else if (wvalid) w_wait++;

            if (bvalid && bready) begin
                n_b++;
                chk("one_aw_w_per_b", {n_aw, n_w}, {n_b, n_b});
                b_pend = 0;
            end

            if (got_aw && got_w && !b_pend) begin
                logic [23:0] off;
                bit bad;
                off = wr_addr - BASE;
                mem[wr_addr] = wr_data;
                bad = (mode == 3) ? (off[9:2] == 8'd3) :
                      (mode == 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
                b_code = bad ? 2'b10 : 2'b00;
                if (bad) exp_err++;
                b_pend = 1; b_cnt = pick(3);
                got_aw = 0; got_w = 0;
            end

            if (arvalid && arready) begin
                if (exp_ar.size() == 0) fail("ar_extra");
                else chk("araddr", araddr, exp_ar.pop_front());
                chk("rd_after_b", n_b, n_ar + 1);
                r_data = mem.exists(araddr) ? mem[araddr] : 32'h0;
                r_code = 2'b00;
                if (mode == 3 && n_ar == 2) r_data ^= 32'h0000_0100;
                if (mode == 0 && $urandom_range(0, 7) == 0)
                    r_data ^= (32'h1 << $urandom_range(0, 31));
                if (mode == 0 && $urandom_range(0, 7) == 0) r_code = 2'b10;
                if (r_data != ref_pat(n_ar) || r_code != 2'b00) exp_err++;
                last_exp = r_data;
                n_ar++;
                ar_wait = 0; ar_dly = pick(2);
                r_pend = 1; r_cnt = pick(4);
            end else if (arvalid) ar_wait++;

            if (rvalid && rready) r_pend = 0;

            aw_stall = awvalid && !awready; aw_prev = awaddr;
            w_stall  = wvalid && !wready;   w_prev  = wdata;
            ar_stall = arvalid && !arready; ar_prev = araddr;
        end
    end

    task automatic prepare();
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); mem.delete();
        exp_err = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0;
        aw_hi = 0; w_hi = 0;
        aw_dly = pick(0); w_dly = pick(1); ar_dly = pick(2);
        for (int i = 0; i < NW; i++) begin
            exp_aw.push_back(ref_addr(i));
            exp_w.push_back(ref_pat(i));
            exp_ar.push_back(ref_addr(i));
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) fail("done_timeout");
    endtask

    task automatic end_checks(string nm);
        chk({nm, "_done"}, {done, busy}, 2'b10);
        chk({nm, "_err"}, err_count, (exp_err > 255) ? 255 : exp_err);
        chk({nm, "_last"}, last_rdata, last_exp);
        chk({nm, "_idx"}, word_idx, 8'(NW));
        chk({nm, "_queues"}, exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
    endtask

    task automatic run_pulse(int m, string nm);
        mode = m;
        @(negedge clk);
        prepare();
        start = 1;
        @(negedge clk);
        start = 0;
        if (!done) wait_done();
        end_checks(nm);
    endtask

    task automatic chk_reset(string nm);
        chk({nm, "_valids"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk({nm, "_status"}, {busy, done}, 0);
        chk({nm, "_addr"}, {awaddr, araddr}, 0);
        chk({nm, "_wdata"}, {wdata, wstrb}, 0);
        chk({nm, "_err"}, err_count, 0);
        chk({nm, "_last"}, last_rdata, 0);
        chk({nm, "_idx"}, word_idx, 0);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        #2 rst_n = 1;
        repeat (2) @(negedge clk);

        run_pulse(1, "zero_wait");
        chk("zero_wait_pattern", last_rdata, 32'hA503FFFC);
        run_pulse(2, "slow_aw");
        run_pulse(3, "faults");
        chk("faults_count", err_count, 2);
        for (int r = 0; r < 8; r++) run_pulse(0, "random");

        // Reset during the read response of word 1.
        mode = 1;
        @(negedge clk);
        prepare();
        start = 1;
        @(negedge clk);
        start = 0;
        found = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            #2;
            if (rready && word_idx == 8'd1) begin found = 1; break; end
        end
        if (!found) fail("rd_resp_word1");
        rst_n = 0;
        #1;
        chk_reset("mid_reset");
        @(negedge clk);
        #2 rst_n = 1;
        run_pulse(1, "after_reset");

        // start held high through a run and into the next one.
        mode = 1;
        @(negedge clk);
        prepare();
        start = 1;
        wait_done();
        end_checks("held");
        prepare();
        @(negedge clk);
        chk("held_restart", {busy, done}, 2'b10);
        start = 0;
        wait_done();
        end_checks("held_second");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_write_readback_seq.md
AXI_WRITE_READBACK_SEQ -- requirements
Module: axi_write_readback_seq

Interface
REQ-001 Parameter ADDR_SIZE, default 24, sets the AXI4-Lite address width.
REQ-002 Parameter DATA_SIZE, default 32, sets the AXI4-Lite data width; only 32 is supported.
REQ-003 Parameter NUM_WORDS, default 16, sets the words per run (1..256).
REQ-004 Parameter BASE_ADDR, default 0, sets the first byte address of a run.
REQ-005 Port ACLK, input, 1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port ARESETn, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: run request, sampled in IDLE or DONE.
REQ-008 Ports awaddr (out, ADDR_SIZE), awvalid (out, 1) and awready (in, 1) form the write-address channel.
REQ-009 Ports wdata (out, 32), wstrb (out, 4), wvalid (out, 1) and wready (in, 1) form the write-data channel.
REQ-010 Ports bresp (in, 2), bvalid (in, 1) and bready (out, 1) form the write-response channel.
REQ-011 Ports araddr (out, ADDR_SIZE), arvalid (out, 1) and arready (in, 1) form the read-address channel.
REQ-012 Ports rdata (in, 32), rresp (in, 2), rvalid (in, 1) and rready (out, 1) form the read-data channel.
REQ-013 Status outputs: busy (1), done (1), err_count (8), last_rdata (32) and word_idx (8).

Function
REQ-014 The FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and DONE.
REQ-015 IDLE/DONE -> WR_REQ when start=1; word_idx and err_count are cleared and done drops in that same cycle.
REQ-016 For word i, the address SHALL be BASE_ADDR + 4*i, truncated to ADDR_SIZE bits (wrap-around permitted).
REQ-017 For word i, the data SHALL be {8'hA5, 8'(i), 16'(~i)}, and wstrb SHALL be 4'hF.
REQ-018 On entering WR_REQ, awvalid and wvalid SHALL both assert in the same cycle.
REQ-019 Each valid SHALL drop in the cycle after its own handshake (valid&ready), independently of the other.
REQ-020 Address and data SHALL stay stable while their valid is high.
REQ-021 WR_REQ -> WR_RESP once both handshakes are complete, including when both complete in the same cycle.
REQ-022 bready SHALL be high only in WR_RESP; on bvalid, the FSM goes to RD_REQ, and err_count is incremented if bresp != 0.
REQ-023 In RD_REQ, arvalid SHALL be high with araddr equal to the REQ-016 address; on arready the FSM goes to RD_RESP.
REQ-024 rready SHALL be high only in RD_RESP; on rvalid, last_rdata captures rdata.
REQ-025 On the RD_RESP rvalid cycle, err_count is incremented once if rdata != expected data or rresp != 0 (both bad counts once).
REQ-026 After RD_RESP, word_idx increments and the FSM goes to WR_REQ, or to DONE if word_idx was NUM_WORDS-1.
REQ-027 err_count SHALL saturate at 255.
REQ-028 busy=1 in every state except IDLE and DONE.
REQ-029 done=1 while in DONE.
REQ-030 start SHALL be ignored while busy.
REQ-031 The block SHALL not time out; a stalled slave holds it in the current state.
REQ-032 At most one transaction SHALL be outstanding; the read of word i always follows the write response of word i.

Reset
REQ-033 ARESETn low SHALL immediately force IDLE, including mid-transaction.
REQ-034 On reset, all valid/ready outputs go to 0, awaddr/araddr/wdata go to 0 and wstrb goes to 0.
REQ-035 On reset, busy, done, err_count, last_rdata and word_idx go to 0.
REQ-036 Deassertion SHALL be usable synchronously; the first transaction starts no earlier than the second ACLK edge after release.

Structure
REQ-037 Package axi_seq_pkg SHALL hold the state enum, the AXI response codes (OKAY=2'b00, SLVERR=2'b10) and the 8'hA5 pattern tag.
REQ-038 A pattern generator function (word index -> data) SHALL live in the package; the block has no sub-module.
REQ-039 The block SHALL be usable as the master on the team's axi4_lite_if.

Verification
REQ-040 Zero-wait slave, NUM_WORDS=4, start pulse -> 4 writes and 4 reads at 0x0/0x4/0x8/0xC; done=1; err_count=0; last_rdata=32'hA503FFFC.
REQ-041 awready delayed 3 cycles with wready immediate -> wvalid drops after 1 cycle, awvalid holds 4 cycles, and each channel has exactly one handshake.
REQ-042 Slave corrupts the read of word 2 and returns bresp=SLVERR on word 3 -> err_count=2 at done.
REQ-043 ARESETn pulsed low in RD_RESP of word 1 -> all outputs 0 immediately; a new start restarts at address BASE_ADDR.
REQ-044 BASE_ADDR=24'hFFFFF8, NUM_WORDS=4 -> addresses FFFFF8, FFFFFC, 000000, 000004.
REQ-045 start held high through the run -> no restart while busy; a new run begins the cycle after DONE is reached.
